// File: rtl/sensor_chain_pkg.sv
// sensor_chain_pkg: shared FSM state encoding and parameter defaults for the sensor chain master
package sensor_chain_pkg;
  localparam int NUM_SENSORS_DEF = 4;
  localparam int FRAME_W_DEF = 16;
  localparam int CLK_DIV_DEF = 4;
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CS_SETUP = 3'd1,
    SHIFT    = 3'd2,
    CS_HOLD  = 3'd3,
    FIN      = 3'd4
  } state_e;
endpackage

// File: rtl/sensor_chain_clkgen.sv
// sensor_chain_clkgen: divided SPI clock with one-cycle rise/fall enables, held low while disabled
module sensor_chain_clkgen import sensor_chain_pkg::*; #(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic spi_clk,
  output logic rise,
  output logic fall
);
  localparam int CW = $clog2(CLK_DIV + 1);
  logic [CW-1:0] cnt;
  logic tick;
  assign tick = en && cnt == CW'(CLK_DIV - 1);
  assign rise = tick && !spi_clk;
  assign fall = tick && spi_clk;
  // half-period counter; the first rise lands CLK_DIV cycles after enable
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt <= '0;
      spi_clk <= 1'b0;
    end else if (tick) begin
      cnt <= '0;
      spi_clk <= !spi_clk;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/sensor_chain_master.sv
// sensor_chain_master: SPI daisy-chain master with microcontroller bypass; optional PAR_ERR via SENSOR_CHAIN_PARITY_EN
module sensor_chain_master import sensor_chain_pkg::*; #(
  parameter int NUM_SENSORS = NUM_SENSORS_DEF,
  parameter int FRAME_W = FRAME_W_DEF,
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic START,
  input  logic [FRAME_W-1:0] CMD,
  input  logic UC_BYPASS,
  input  logic SPI_CS_UC,
  input  logic SPI_CLK_UC,
  input  logic SPI_MOSI_UC,
  output logic SPI_MISO_UC,
  output logic SPI_CS,
  output logic SPI_CLK,
  output logic SPI_MOSI,
  input  logic SPI_MISO,
  output logic BUSY,
  output logic DONE,
`ifdef SENSOR_CHAIN_PARITY_EN
  output logic [NUM_SENSORS-1:0] PAR_ERR,
`endif
  input  logic [(NUM_SENSORS > 1 ? $clog2(NUM_SENSORS) : 1)-1:0] RD_IDX,
  output logic [FRAME_W-1:0] RD_DATA
);
  localparam int NB = NUM_SENSORS * FRAME_W;
  localparam int CW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(NB + 1);
  state_e state, nxt;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bits;
  logic [FRAME_W-1:0] cmd_q;
  logic [NB-1:0] shadow, res;
  logic spi_clk_i, rise, fall, phase_end, shift_end;

  sensor_chain_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk(CLK),
    .rst(RST),
    .en(state == SHIFT),
    .spi_clk(spi_clk_i),
    .rise(rise),
    .fall(fall)
  );

  assign phase_end = cnt == CW'(CLK_DIV - 1);
  assign shift_end = fall && bits == BW'(NB - 1);

  // next state; bypass aborts any transfer immediately
  always_comb begin
    nxt = UC_BYPASS ? IDLE :
          state == IDLE     ? (START ? CS_SETUP : IDLE) :
          state == CS_SETUP ? (phase_end ? SHIFT : CS_SETUP) :
          state == SHIFT    ? (shift_end ? CS_HOLD : SHIFT) :
          state == CS_HOLD  ? (phase_end ? FIN : CS_HOLD) : IDLE;
  end

  // state, phase timing, command rotation, capture and commit of results
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt <= '0;
      bits <= '0;
      cmd_q <= '0;
      shadow <= '0;
      res <= '0;
    end else begin
      state <= nxt;
      cnt <= (nxt != state) ? '0 : cnt + CW'(1);
      bits <= (state == SHIFT) ? bits + BW'(fall) : '0;
      if (state == IDLE && START) cmd_q <= CMD;
      else if (fall) cmd_q <= {cmd_q[FRAME_W-2:0], cmd_q[FRAME_W-1]};
      if (rise) shadow <= {shadow[NB-2:0], SPI_MISO};
      if (nxt == FIN) res <= shadow;
    end
  end

`ifdef SENSOR_CHAIN_PARITY_EN
  // per-frame parity of the captured data, committed alongside the results
  always_ff @(posedge CLK) begin
    if (RST) PAR_ERR <= '0;
    else if (nxt == FIN) for (int i = 0; i < NUM_SENSORS; i++) PAR_ERR[i] <= ^shadow[i*FRAME_W +: FRAME_W];
  end
`endif

  assign SPI_CS = UC_BYPASS ? SPI_CS_UC : (state == IDLE || state == FIN);
  assign SPI_CLK = UC_BYPASS ? SPI_CLK_UC : spi_clk_i;
  assign SPI_MOSI = UC_BYPASS ? SPI_MOSI_UC : (state == SHIFT && cmd_q[FRAME_W-1]);
  assign SPI_MISO_UC = UC_BYPASS && SPI_MISO;
  assign BUSY = state != IDLE;
  assign DONE = state == FIN;
  assign RD_DATA = (32'(RD_IDX) < NUM_SENSORS) ? res[RD_IDX*FRAME_W +: FRAME_W] : '0;
endmodule
